axi_sram_write_slave: RTL and testbench

//  AXI4 slave-side write responder in front of a single-port SRAM (IM/DM wrapper side).
//  - Accepts one AW burst from the interconnect and takes the W beats; issues one B response.
//  - Sits downstream of the interconnect write-address/data routing (S0/S1 ports).
//  - Turns W beats into per-beat SRAM byte-masked writes.

---
 rtl/axi_pkg.sv | 32 +++
 rtl/axi_burst_addr_gen.sv | 23 ++
 rtl/axi_sram_write_slave.sv | 168 ++++++++++++++++
 tb/tb_axi_sram_write_slave.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_pkg
// Brief   : Shared widths, response/burst codes and write FSM states for the
//           AXI SRAM write slave.
// Revision: 1.0 - initial release
// ============================================================================
package axi_pkg;

    localparam int AXI_ADDR_BITS     = 32;
    localparam int AXI_DATA_BITS     = 32;
    localparam int AXI_IDS_BITS      = 8;
    localparam int AXI_LEN_BITS      = 4;
    localparam int AXI_MEM_ADDR_BITS = 14;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [2:0] SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WDATA = 2'd1,
        BRESP = 2'd2
    } wr_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
`default_nettype none
// ============================================================================
// Module  : axi_burst_addr_gen
// Brief   : Combinational SRAM word address for the current beat; the INCR
//           add wraps modulo the SRAM address space.
// Revision: 1.0 - initial release
// ============================================================================
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int MEM_ADDR_BITS = AXI_MEM_ADDR_BITS,
    parameter int CNT_BITS      = AXI_LEN_BITS + 1
) (
    input  logic [MEM_ADDR_BITS-1:0] base,
    input  logic [CNT_BITS-1:0]      cnt,
    input  logic [1:0]               burst,
    output logic [MEM_ADDR_BITS-1:0] mem_addr
);

    assign mem_addr = (burst == BURST_FIXED) ? base : base + MEM_ADDR_BITS'(cnt);

endmodule
`default_nettype wire

// File: rtl/axi_sram_write_slave.sv
`default_nettype none
// ============================================================================
// Module  : axi_sram_write_slave
// Brief   : AXI4 write responder turning W beats into byte-masked SRAM writes.
//           Optional protocol checking via macro AXI_WR_ERRCHK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module axi_sram_write_slave #(
    parameter int ADDR_BITS     = axi_pkg::AXI_ADDR_BITS,
    parameter int DATA_BITS     = axi_pkg::AXI_DATA_BITS,
    parameter int IDS_BITS      = axi_pkg::AXI_IDS_BITS,
    parameter int LEN_BITS      = axi_pkg::AXI_LEN_BITS,
    parameter int MEM_ADDR_BITS = axi_pkg::AXI_MEM_ADDR_BITS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [IDS_BITS-1:0]      AWID,
    input  logic [ADDR_BITS-1:0]     AWADDR,
    input  logic [LEN_BITS-1:0]      AWLEN,
    input  logic [2:0]               AWSIZE,
    input  logic [1:0]               AWBURST,
    input  logic                     AWVALID,
    output logic                     AWREADY,
    input  logic [DATA_BITS-1:0]     WDATA,
    input  logic [DATA_BITS/8-1:0]   WSTRB,
    input  logic                     WLAST,
    input  logic                     WVALID,
    output logic                     WREADY,
    output logic [IDS_BITS-1:0]      BID,
    output logic [1:0]               BRESP,
    output logic                     BVALID,
    input  logic                     BREADY,
    output logic                     mem_cs,
    output logic [DATA_BITS/8-1:0]   mem_we,
    output logic [MEM_ADDR_BITS-1:0] mem_addr,
    output logic [DATA_BITS-1:0]     mem_wdata
);

    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int CNT_BITS  = LEN_BITS + 1;

    axi_pkg::wr_state_t r_state;
    axi_pkg::wr_state_t w_state_nxt;

    logic [IDS_BITS-1:0]      r_id;
    logic [MEM_ADDR_BITS-1:0] r_base;
    logic [1:0]               r_burst;
    logic [CNT_BITS-1:0]      r_cnt;

    logic                     w_aw_hs;
    logic                     w_w_hs;
    logic                     w_b_hs;
    logic                     w_write_ok;
    logic                     w_err;
    logic                     w_cs;
    logic                     w_unused;
    logic [MEM_ADDR_BITS-1:0] w_addr;

    // Handshakes are masked by rst so nothing is latched or written while in reset.
    assign w_aw_hs = !rst && AWVALID && (r_state == axi_pkg::IDLE);
    assign w_w_hs  = !rst && WVALID  && (r_state == axi_pkg::WDATA);
    assign w_b_hs  = !rst && BREADY  && (r_state == axi_pkg::BRESP);
    assign w_cs    = w_w_hs && w_write_ok;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            axi_pkg::IDLE:  if (w_aw_hs)          w_state_nxt = axi_pkg::WDATA;
            axi_pkg::WDATA: if (w_w_hs && WLAST)  w_state_nxt = axi_pkg::BRESP;
            axi_pkg::BRESP: if (w_b_hs)           w_state_nxt = axi_pkg::IDLE;
            default:                              w_state_nxt = axi_pkg::IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= axi_pkg::IDLE;
            r_id    <= '0;
            r_base  <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_aw_hs) begin
                r_id    <= AWID;
                r_base  <= AWADDR[MEM_ADDR_BITS+1:2];
                r_burst <= AWBURST;
                r_cnt   <= '0;
            end else if (w_w_hs) begin
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

`ifdef AXI_WR_ERRCHK_EN
    logic [LEN_BITS-1:0] r_len;
    logic                r_err;
    logic                r_suppress;
    logic                r_past;
    logic                w_aw_bad;

    assign w_aw_bad = (AWSIZE != axi_pkg::SIZE_WORD) ||
                      ((AWBURST != axi_pkg::BURST_FIXED) && (AWBURST != axi_pkg::BURST_INCR));

    // r_past: the beat with cnt == len has been taken, so every later beat is surplus.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len      <= '0;
            r_err      <= 1'b0;
            r_suppress <= 1'b0;
            r_past     <= 1'b0;
        end else if (w_aw_hs) begin
            r_len      <= AWLEN;
            r_err      <= w_aw_bad;
            r_suppress <= w_aw_bad;
            r_past     <= 1'b0;
        end else if (w_w_hs) begin
            if (r_past || (WLAST && (r_cnt != {1'b0, r_len})))
                r_err <= 1'b1;
            if (r_cnt == {1'b0, r_len})
                r_past <= 1'b1;
        end
    end

    assign w_write_ok = !r_suppress && !r_past;
    assign w_err      = r_err;
    assign w_unused   = ^{AWADDR[ADDR_BITS-1:MEM_ADDR_BITS+2], AWADDR[1:0]};
`else
    assign w_write_ok = 1'b1;
    assign w_err      = 1'b0;
    assign w_unused   = ^{AWADDR[ADDR_BITS-1:MEM_ADDR_BITS+2], AWADDR[1:0], AWSIZE, AWLEN};
`endif

    axi_burst_addr_gen #(
        .MEM_ADDR_BITS (MEM_ADDR_BITS),
        .CNT_BITS      (CNT_BITS)
    ) u_addr_gen (
        .base     (r_base),
        .cnt      (r_cnt),
        .burst    (r_burst),
        .mem_addr (w_addr)
    );

    always_comb begin
        AWREADY   = 1'b0;
        WREADY    = 1'b0;
        BVALID    = 1'b0;
        BID       = '0;
        BRESP     = axi_pkg::RESP_OKAY;
        mem_cs    = 1'b0;
        mem_we    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (!rst) begin
            AWREADY   = (r_state == axi_pkg::IDLE);
            WREADY    = (r_state == axi_pkg::WDATA);
            BVALID    = (r_state == axi_pkg::BRESP);
            BID       = r_id;
            BRESP     = w_err ? axi_pkg::RESP_SLVERR : axi_pkg::RESP_OKAY;
            mem_cs    = w_cs;
            mem_we    = w_cs ? WSTRB : {STRB_BITS{1'b0}};
            mem_addr  = w_addr;
            mem_wdata = WDATA;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_sram_write_slave.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_sram_write_slave
// Brief   : Randomised and directed self-checking bench for axi_sram_write_slave.
// Revision: 1.0 - initial release
// ============================================================================
module tb_axi_sram_write_slave;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  AWID = '0;
    logic [31:0] AWADDR = '0;
    logic [3:0]  AWLEN = '0;
    logic [2:0]  AWSIZE = 3'd2;
    logic [1:0]  AWBURST = 2'd1;
    logic        AWVALID = 1'b0;
    logic        AWREADY;
    logic [31:0] WDATA = '0;
    logic [3:0]  WSTRB = '0;
    logic        WLAST = 1'b0;
    logic        WVALID = 1'b0;
    logic        WREADY;
    logic [7:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY = 1'b0;
    logic        mem_cs;
    logic [3:0]  mem_we;
    logic [13:0] mem_addr;
    logic [31:0] mem_wdata;

    int total = 0;
    int bad   = 0;

    // Observations gathered by do_burst; each test judges them itself.
    int          obs_addr[$];
    int          obs_beat[$];
    logic [3:0]  obs_we[$];
    logic [31:0] obs_data[$];
    logic [31:0] hs_data[$];
    logic [3:0]  hs_strb[$];
    int          obs_extra, obs_unstable, obs_to;
    logic        obs_wready_aw, obs_bvalid_now, obs_bvalid_after, obs_awready_after;
    logic [7:0]  obs_bid;
    logic [1:0]  obs_bresp;

    axi_sram_write_slave dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata)
    );

    always #5 clk = ~clk;

    function automatic int exp_maddr(input logic [31:0] addr, input logic [1:0] burst, input int i);
        int word;
        word = int'(addr >> 2);
        return (burst == 2'd0) ? (word % 16384) : ((word + i) % 16384);
    endfunction

    function automatic bit exp_written(input logic [2:0] size, input logic [1:0] burst,
                                       input int len, input int i);
`ifdef AXI_WR_ERRCHK_EN
        return (size == 3'd2) && (burst <= 2'd1) && (i <= len);
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [1:0] exp_resp(input logic [2:0] size, input logic [1:0] burst,
                                            input int len, input int nbeats);
`ifdef AXI_WR_ERRCHK_EN
        return ((size != 3'd2) || (burst > 2'd1) || (nbeats != len + 1)) ? 2'b10 : 2'b00;
`else
        return 2'b00;
`endif
    endfunction

    task automatic do_burst(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input int nbeats,
                            input int gap_pct, input int bwait, input bit use_d0,
                            input logic [31:0] d0);
        int t;
        int i;
        logic v;
        logic [7:0] bid0;
        logic [1:0] br0;
        obs_addr.delete(); obs_beat.delete(); obs_we.delete(); obs_data.delete();
        hs_data.delete(); hs_strb.delete();
        obs_extra = 0; obs_unstable = 0; obs_to = 0;
        @(negedge clk);
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        #1;
        t = 0;
        while (!AWREADY && t < 50) begin @(negedge clk); #1; t++; end
        if (!AWREADY) obs_to++;
        @(posedge clk); #1;
        AWVALID = 1'b0; AWID = 8'($urandom); AWADDR = $urandom; AWLEN = 4'($urandom);
        obs_wready_aw = WREADY;
        i = 0; t = 0;
        while (i < nbeats && t < 400) begin
            @(negedge clk);
            v = ($urandom_range(99) >= gap_pct);
            WVALID = v;
            WDATA  = (use_d0 && i == 0) ? d0 : $urandom;
            WSTRB  = (use_d0 && i == 0) ? 4'hF : 4'($urandom);
            WLAST  = (i == nbeats - 1);
            #1;
            if (BVALID) obs_extra++;
            if (mem_cs) begin
                if (v && WREADY) begin
                    obs_addr.push_back(int'(mem_addr)); obs_beat.push_back(i);
                    obs_we.push_back(mem_we); obs_data.push_back(mem_wdata);
                end else obs_extra++;
            end else if (mem_we != 4'h0) obs_extra++;
            if (v && WREADY) begin
                hs_data.push_back(WDATA); hs_strb.push_back(WSTRB); i++;
            end
            @(posedge clk); t++;
        end
        if (i < nbeats) obs_to++;
        #1;
        WVALID = 1'b0; WLAST = 1'b0;
        obs_bvalid_now = BVALID;
        bid0 = BID; br0 = BRESP;
        for (int k = 0; k < bwait; k++) begin
            @(negedge clk);
            WVALID = 1'($urandom);
            #1;
            if (!BVALID || BID !== bid0 || BRESP !== br0 || AWREADY || WREADY || mem_cs)
                obs_unstable++;
        end
        @(negedge clk);
        WVALID = 1'b0; BREADY = 1'b1;
        #1;
        t = 0;
        while (!BVALID && t < 50) begin @(negedge clk); #1; t++; end
        if (!BVALID) obs_to++;
        obs_bid = BID; obs_bresp = BRESP;
        @(posedge clk); #1;
        BREADY = 1'b0;
        obs_bvalid_after  = BVALID;
        obs_awready_after = AWREADY;
    endtask

    task automatic test_reset();
        rst = 1'b1; AWVALID = 1'b1; WVALID = 1'b1; BREADY = 1'b1; WDATA = 32'hA5A5_5A5A; WSTRB = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        total++;
        if ({AWREADY, WREADY, BVALID, mem_cs} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0000", {AWREADY, WREADY, BVALID, mem_cs});
        end
        total++;
        if ({BID, BRESP, mem_we, mem_addr, mem_wdata} !== '0) begin
            bad++; $display("FAIL reset_data: got bid=%h bresp=%h we=%h addr=%h data=%h want all 0",
                            BID, BRESP, mem_we, mem_addr, mem_wdata);
        end
        rst = 1'b0; AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        #1;
        total++;
        if ({AWREADY, WREADY, BVALID} !== 3'b100) begin
            bad++; $display("FAIL reset_idle: got aw/w/b=%b want 100", {AWREADY, WREADY, BVALID});
        end
    endtask

    task automatic test_single_beat();
        do_burst(8'h11, 32'h0000_0010, 4'd0, 3'd2, 2'd1, 1, 0, 0, 1'b1, 32'hDEAD_BEEF);
        total++;
        if (obs_to != 0 || obs_addr.size() != 1) begin
            bad++; $display("FAIL single_count: got to=%0d writes=%0d want 0/1", obs_to, obs_addr.size());
        end else begin
            total++;
            if (obs_addr[0] != 4 || obs_we[0] !== 4'hF || obs_data[0] !== 32'hDEAD_BEEF) begin
                bad++; $display("FAIL single_write: got addr=%0h we=%h data=%h want 4/F/deadbeef",
                                obs_addr[0], obs_we[0], obs_data[0]);
            end
        end
        total++;
        if (obs_wready_aw !== 1'b1) begin
            bad++; $display("FAIL single_wready_lat: got %b want 1", obs_wready_aw);
        end
        total++;
        if (obs_bvalid_now !== 1'b1 || obs_bid !== 8'h11 || obs_bresp !== 2'b00) begin
            bad++; $display("FAIL single_b: got bvalid=%b bid=%h bresp=%b want 1/11/00",
                            obs_bvalid_now, obs_bid, obs_bresp);
        end
    endtask

    task automatic test_incr_burst();
        do_burst(8'h22, 32'h0000_0100, 4'd3, 3'd2, 2'd1, 4, 0, 0, 1'b0, 32'h0);
        total++;
        if (obs_to != 0 || obs_addr.size() != 4) begin
            bad++; $display("FAIL incr_count: got to=%0d writes=%0d want 0/4", obs_to, obs_addr.size());
        end else begin
            for (int j = 0; j < 4; j++) begin
                total++;
                if (obs_addr[j] != 'h40 + j || obs_we[j] !== hs_strb[j] || obs_data[j] !== hs_data[j]) begin
                    bad++; $display("FAIL incr_beat%0d: got addr=%0h we=%h data=%h want %0h/%h/%h", j,
                                    obs_addr[j], obs_we[j], obs_data[j], 'h40 + j, hs_strb[j], hs_data[j]);
                end
            end
        end
        total++;
        if (obs_bvalid_now !== 1'b1 || obs_extra != 0) begin
            bad++; $display("FAIL incr_b_lat: got bvalid=%b extra=%0d want 1/0", obs_bvalid_now, obs_extra);
        end
    endtask

    task automatic test_fixed_wrap();
        do_burst(8'h33, 32'h0000_0020, 4'd1, 3'd2, 2'd0, 2, 0, 0, 1'b0, 32'h0);
        total++;
        if (obs_addr.size() != 2 || obs_addr[0] != 8 || obs_addr[1] != 8) begin
            bad++; $display("FAIL fixed_addr: got n=%0d a0=%0h a1=%0h want 2/8/8", obs_addr.size(),
                            obs_addr.size() > 0 ? obs_addr[0] : -1, obs_addr.size() > 1 ? obs_addr[1] : -1);
        end
        do_burst(8'h34, 32'h0000_FFFC, 4'd1, 3'd2, 2'd1, 2, 0, 0, 1'b0, 32'h0);
        total++;
        if (obs_addr.size() != 2 || obs_addr[0] != 'h3FFF || obs_addr[1] != 0) begin
            bad++; $display("FAIL wrap_addr: got n=%0d a0=%0h a1=%0h want 2/3fff/0", obs_addr.size(),
                            obs_addr.size() > 0 ? obs_addr[0] : -1, obs_addr.size() > 1 ? obs_addr[1] : -1);
        end
    endtask

    task automatic test_backpressure();
        do_burst(8'h5C, 32'h0000_0400, 4'd3, 3'd2, 2'd1, 4, 50, 5, 1'b0, 32'h0);
        total++;
        if (obs_to != 0 || obs_addr.size() != 4 || obs_extra != 0) begin
            bad++; $display("FAIL bp_writes: got to=%0d writes=%0d extra=%0d want 0/4/0",
                            obs_to, obs_addr.size(), obs_extra);
        end
        total++;
        if (obs_unstable != 0 || obs_bid !== 8'h5C) begin
            bad++; $display("FAIL bp_hold: got unstable=%0d bid=%h want 0/5c", obs_unstable, obs_bid);
        end
        total++;
        if (obs_bvalid_after !== 1'b0 || obs_awready_after !== 1'b1) begin
            bad++; $display("FAIL bp_release: got bvalid=%b awready=%b want 0/1",
                            obs_bvalid_after, obs_awready_after);
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        AWID = 8'h77; AWADDR = 32'h200; AWLEN = 4'd3; AWSIZE = 3'd2; AWBURST = 2'd1; AWVALID = 1'b1;
        @(posedge clk); #1;
        AWVALID = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); WVALID = 1'b1; WLAST = 1'b0; WDATA = $urandom; WSTRB = 4'hF;
            @(posedge clk);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if ({AWREADY, BVALID, mem_cs, mem_we} !== 7'b0) begin
            bad++; $display("FAIL rstmid_now: got aw=%b b=%b cs=%b we=%h want 0", AWREADY, BVALID, mem_cs, mem_we);
        end
        @(negedge clk); #1;
        total++;
        if ({AWREADY, BVALID, mem_cs} !== 3'b0) begin
            bad++; $display("FAIL rstmid_next: got aw=%b b=%b cs=%b want 000", AWREADY, BVALID, mem_cs);
        end
        rst = 1'b0; WVALID = 1'b0;
        #1;
        total++;
        if ({AWREADY, WREADY, BVALID, mem_cs} !== 4'b1000) begin
            bad++; $display("FAIL rstmid_idle: got aw/w/b/cs=%b want 1000", {AWREADY, WREADY, BVALID, mem_cs});
        end
        do_burst(8'h78, 32'h0000_0300, 4'd0, 3'd2, 2'd1, 1, 0, 0, 1'b0, 32'h0);
        total++;
        if (obs_to != 0 || obs_addr.size() != 1 || obs_bid !== 8'h78 || obs_bresp !== 2'b00) begin
            bad++; $display("FAIL rstmid_new_aw: got to=%0d writes=%0d bid=%h bresp=%b want 0/1/78/00",
                            obs_to, obs_addr.size(), obs_bid, obs_bresp);
        end else begin
            total++;
            if (obs_addr[0] != 'hC0) begin
                bad++; $display("FAIL rstmid_addr: got %0h want c0", obs_addr[0]);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          nb;
        int          nexp;
        for (int n = 0; n < 24; n++) begin
            id = 8'($urandom); addr = $urandom; len = 4'($urandom);
`ifdef AXI_WR_ERRCHK_EN
            size  = ($urandom_range(3) == 0) ? 3'($urandom) : 3'd2;
            burst = ($urandom_range(3) == 0) ? 2'($urandom) : 2'($urandom_range(1));
`else
            size  = 3'($urandom);
            burst = 2'($urandom_range(1));
`endif
            nb = ($urandom_range(3) == 0) ? int'($urandom_range(1, 16)) : int'(len) + 1;
            do_burst(id, addr, len, size, burst, nb, $urandom_range(40), $urandom_range(3), 1'b0, 32'h0);
            nexp = 0;
            for (int i = 0; i < nb; i++) if (exp_written(size, burst, len, i)) nexp++;
            total++;
            if (obs_to != 0 || obs_addr.size() != nexp || obs_extra != 0) begin
                bad++; $display("FAIL rand%0d_count: got to=%0d writes=%0d extra=%0d want 0/%0d/0",
                                n, obs_to, obs_addr.size(), obs_extra, nexp);
            end
            for (int j = 0; j < obs_addr.size(); j++) begin
                total++;
                if (!exp_written(size, burst, len, obs_beat[j]) ||
                    obs_addr[j] != exp_maddr(addr, burst, obs_beat[j]) ||
                    obs_we[j] !== hs_strb[obs_beat[j]] || obs_data[j] !== hs_data[obs_beat[j]]) begin
                    bad++; $display("FAIL rand%0d_beat%0d: got addr=%0h we=%h data=%h want %0h/%h/%h",
                                    n, obs_beat[j], obs_addr[j], obs_we[j], obs_data[j],
                                    exp_maddr(addr, burst, obs_beat[j]), hs_strb[obs_beat[j]],
                                    hs_data[obs_beat[j]]);
                end
            end
            total++;
            if (obs_bvalid_now !== 1'b1 || obs_bid !== id || obs_bresp !== exp_resp(size, burst, len, nb) ||
                obs_unstable != 0 || obs_bvalid_after !== 1'b0 || obs_awready_after !== 1'b1) begin
                bad++; $display("FAIL rand%0d_b: got bv=%b bid=%h bresp=%b unst=%0d want 1/%h/%b/0",
                                n, obs_bvalid_now, obs_bid, obs_bresp, obs_unstable, id,
                                exp_resp(size, burst, len, nb));
            end
        end
    endtask

`ifdef AXI_WR_ERRCHK_EN
    task automatic test_errchk();
        do_burst(8'h41, 32'h0000_0500, 4'd3, 3'd2, 2'd1, 3, 0, 0, 1'b0, 32'h0);
        total++;
        if (obs_bresp !== 2'b10 || obs_addr.size() != 3) begin
            bad++; $display("FAIL err_short: got bresp=%b writes=%0d want 10/3", obs_bresp, obs_addr.size());
        end
        do_burst(8'h42, 32'h0000_0600, 4'd1, 3'd1, 2'd1, 2, 0, 0, 1'b0, 32'h0);
        total++;
        if (obs_bresp !== 2'b10 || obs_addr.size() != 0 || obs_extra != 0) begin
            bad++; $display("FAIL err_size: got bresp=%b writes=%0d want 10/0", obs_bresp, obs_addr.size());
        end
        do_burst(8'h43, 32'h0000_0700, 4'd1, 3'd2, 2'd1, 4, 0, 0, 1'b0, 32'h0);
        total++;
        if (obs_bresp !== 2'b10 || obs_addr.size() != 2 || obs_to != 0) begin
            bad++; $display("FAIL err_long: got bresp=%b writes=%0d to=%0d want 10/2/0",
                            obs_bresp, obs_addr.size(), obs_to);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_beat();
        test_incr_burst();
        test_fixed_wrap();
        test_backpressure();
        test_reset_mid_burst();
`ifdef AXI_WR_ERRCHK_EN
        test_errchk();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
